// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with occupancy flags; define FIFO_FWFT_EN for first-word fall-through reads
module fifo_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_rq,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd_rq,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    waddr, raddr;
    logic             wr_acc, rd_acc;
    assign wr_acc       = wr_rq & ~full;
    assign rd_acc       = rd_rq & ~empty;
    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    always_ff @(posedge clk)
        if (wr_acc) mem[waddr] <= wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            waddr     <= wr_acc ? waddr + AW'(1) : waddr;
            raddr     <= rd_acc ? raddr + AW'(1) : raddr;
            count     <= wr_acc == rd_acc ? count : wr_acc ? count + CW'(1) : count - CW'(1);
            overflow  <= wr_rq & full;
            underflow <= rd_rq & empty;
        end
    end
`ifdef FIFO_FWFT_EN
    assign rdata    = empty ? '0 : mem[raddr];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rdata    <= rd_acc ? mem[raddr] : rdata;
            rd_valid <= rd_acc;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: randomized and directed checks of fifo_sync against a queue model
module tb_fifo_sync;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    logic       clk = 0, rst = 0, wr_rq = 0, rd_rq = 0;
    logic [7:0] wdata = 0, rdata;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
    int         checks = 0, failures = 0;
    logic [7:0] q[$];
    logic [7:0] exp_rdata = 0;
    logic       exp_rv = 0, exp_ovf = 0, exp_unf = 0;

    fifo_sync dut (
        .clk(clk), .rst(rst), .wr_rq(wr_rq), .wdata(wdata), .rd_rq(rd_rq),
        .rdata(rdata), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        int n = q.size();
        chk("count", 32'(count), n);
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_unf));
`ifdef FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(n > 0));
        chk("rdata", 32'(rdata), n > 0 ? 32'(q[0]) : 0);
`else
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        chk("rdata", 32'(rdata), 32'(exp_rdata));
`endif
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        int n;
        wr_rq = w; wdata = d; rd_rq = r;
        @(posedge clk);
        n = q.size();
        exp_ovf = w && n == DEPTH;
        exp_unf = r && n == 0;
        exp_rv  = r && n > 0;
        if (exp_rv) exp_rdata = q.pop_front();
        if (w && n < DEPTH) q.push_back(d);
        #1;
        wr_rq = 0; rd_rq = 0;
        check_state();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1;
        repeat (cycles) @(posedge clk);
        q.delete();
        exp_rdata = 0; exp_rv = 0; exp_ovf = 0; exp_unf = 0;
        #1;
        rst = 0;
        check_state();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset(2);
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        step(1, 8'hAA, 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1, 8'(r * 10 + i + 8'h40), 0);
            for (int i = 0; i < 10; i++) step(0, 0, 1);
        end
        step(1, 8'h55, 1);
        step(0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0);
        step(1, 8'hEE, 1);
        while (q.size() > 5) step(0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 8'(8'hC0 + i), 1);
        while (q.size() < 9) step(1, 8'($urandom), 0);
        do_reset(1);
        step(1, 8'h3C, 0);
        step(0, 0, 1);
        for (int i = 0; i < 10000; i++) begin
            int wp = ((i / 400) % 2) ? 75 : 30;
            step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < 100 - wp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
